// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line settings and the
// baud-counter width helper. The RX and TX paths both use them.
package uart_pkg;

   localparam int unsigned CLK_HZ_DEF = 50_000_000;
   localparam int unsigned BAUD_DEF   = 115_200;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
      ST_RECOVER = 3'd4
   } uart_state_e;

   // Width of a counter that spans 0..div-1, with one bit of headroom.
   function automatic int unsigned baud_cnt_width(input int unsigned div);
      return $clog2(div) + 1;
   endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-side signal bundle between the serial pin, the FIFO manager and the RX core.
interface uart_rx_core_if;

   logic       RX_Pin;
   logic       RxEn;
   logic [7:0] Rx_Dat;
   logic       RxDoneflg;
   logic       FrameErr;
   logic       Busy;

   modport master (
      output RX_Pin,
      output RxEn,
      input  Rx_Dat,
      input  RxDoneflg,
      input  FrameErr,
      input  Busy
   );

   modport slave (
      input  RX_Pin,
      input  RxEn,
      output Rx_Dat,
      output RxDoneflg,
      output FrameErr,
      output Busy
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter with restart. It flags the half-bit and full-bit points of
// the current bit period and wraps by itself at the end of each period.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_restart,
   output logic o_half_c,
   output logic o_full_c
);

   localparam int unsigned CW   = baud_cnt_width(BAUD_DIV);
   localparam int unsigned HALF = BAUD_DIV / 2;

   logic [CW-1:0] r_cnt;

   // Counts 0..BAUD_DIV-1. Restart forces 0 in the following cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_restart || o_full_c) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_half_c = (r_cnt == CW'(HALF - 1));
   assign o_full_c = (r_cnt == CW'(BAUD_DIV - 1));

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 serial receive engine. It synchronises the pin, detects the start bit,
// samples each bit at mid-period and pulses a done or framing-error flag per frame.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = CLK_HZ_DEF,
   parameter int unsigned BAUD   = BAUD_DEF
) (
   input  logic           CLK,
   input  logic           RST,
   uart_rx_core_if.slave  io_rx
);

   localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;

   localparam logic [2:0] S_IDLE    = ST_IDLE;
   localparam logic [2:0] S_START   = ST_START;
   localparam logic [2:0] S_DATA    = ST_DATA;
   localparam logic [2:0] S_STOP    = ST_STOP;
   localparam logic [2:0] S_RECOVER = ST_RECOVER;

   if (BAUD_DIV < 4) begin : g_baud_div_check
      $error("uart_rx_core: CLK_HZ/BAUD must be at least 4");
   end

   logic       r_sync1;
   logic       r_rx_s;
   logic       r_rx_d;
   logic       w_fall;

   logic [2:0] r_state;
   logic [2:0] w_state_nxt;
   logic [2:0] r_bit_idx;
   logic [2:0] w_bit_idx_nxt;
   logic [7:0] r_shift;
   logic [7:0] w_shift_nxt;
   logic       w_restart;
   logic       w_half;
   logic       w_full;
   logic       w_done_nxt;
   logic       w_err_nxt;

   logic [7:0] r_dat;
   logic       r_done;
   logic       r_err;
   logic       r_busy;

   // Two-flop synchroniser plus one delay stage for the falling-edge detector.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
         r_rx_d  <= 1'b1;
      end else begin
         r_sync1 <= io_rx.RX_Pin;
         r_rx_s  <= r_sync1;
         r_rx_d  <= r_rx_s;
      end
   end

   assign w_fall = r_rx_d & ~r_rx_s;

   uart_baud_tick #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud_tick (
      .clk       (CLK),
      .rst       (RST),
      .i_restart (w_restart),
      .o_half_c  (w_half),
      .o_full_c  (w_full)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
      end
   end

   // The counter is held at zero in IDLE so the start-bit mid-point is
   // measured from the detected edge.
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_restart     = 1'b0;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_restart = 1'b1;
            if (w_fall && io_rx.RxEn) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_half) begin
               w_restart = 1'b1;
               if (!r_rx_s) begin
                  w_state_nxt   = S_DATA;
                  w_bit_idx_nxt = '0;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (w_full) begin
               w_shift_nxt   = {r_rx_s, r_shift[7:1]};
               w_bit_idx_nxt = r_bit_idx + 3'd1;
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (w_full) begin
               if (r_rx_s) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = S_RECOVER;
               end
            end
         end
         S_RECOVER: begin
            // A held-low line (break) must return high before the next frame is accepted.
            if (r_rx_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_dat  <= 8'h00;
         r_done <= 1'b0;
         r_err  <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_done <= w_done_nxt;
         r_err  <= w_err_nxt;
         r_busy <= (w_state_nxt != S_IDLE);
         if (w_done_nxt) begin
            r_dat <= r_shift;
         end
      end
   end

   assign io_rx.Rx_Dat    = r_dat;
   assign io_rx.RxDoneflg = r_done;
   assign io_rx.FrameErr  = r_err;
   assign io_rx.Busy      = r_busy;

endmodule
